jesd204b_rx_link_layer: RTL

- Single-lane JESD204B receive link layer (L=1, M=2, F=4, K=16 words of 4 octets per multiframe). Receive-side counterpart of the team's TX link layer.
- Sits between the GT/8b10b-decode PHY and the ADC/I-Q datapath.
- Drives sync_b through CGS, validates ILAS and captures its configuration octets.
- Undoes character replacement, optionally descrambles, and delivers 16-bit I/Q samples with a valid strobe.

---
 rtl/jesd204b_rx_link_layer.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/jesd204b_rx_link_layer.sv
// Single-lane JESD204B receive link layer (L=1, M=2, F=4).
// CGS/ILAS sync FSM, char-replacement undo, x^15+x^14+1 descrambler.
module jesd204b_rx_link_layer #(
   parameter int K_WORDS   = 16,
   parameter int CGS_MIN   = 4,
   parameter int ILAS_MF   = 4,
   parameter int ERR_LIMIT = 8
) (
   input  logic         clk,
   input  logic         reset_b,
   input  logic [31:0]  rx_par_data,
   input  logic [3:0]   rx_datak,
   input  logic [3:0]   rx_disperr,
   input  logic         descrambler_is_on,
   output logic         sync_b,
   output logic [15:0]  rx_data_i,
   output logic [15:0]  rx_data_q,
   output logic         rx_valid,
   output logic [111:0] ilas_cfg,
   output logic [15:0]  err_cnt,
   output logic [7:0]   state_out
);

   localparam int WCW = (K_WORDS > 1) ? $clog2(K_WORDS) : 1;
   localparam int MFW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
   localparam int KCW = $clog2(CGS_MIN + 1);
   localparam int ECW = $clog2(ERR_LIMIT + 1);

   localparam logic [WCW-1:0] WC_LAST = WCW'(K_WORDS - 1);
   localparam logic [MFW-1:0] MF_LAST = MFW'(ILAS_MF - 1);
   localparam logic [KCW-1:0] K_MIN   = KCW'(CGS_MIN);
   localparam logic [ECW-1:0] E_LIM   = ECW'(ERR_LIMIT);

   typedef enum logic [2:0] {
      SYNC_REQ  = 3'd0,
      CGS       = 3'd1,
      WAIT_ILAS = 3'd2,
      ILAS      = 3'd3,
      DATA      = 3'd4
   } state_t;

   state_t state;
   state_t next;

   // stage 1 input capture
   logic [31:0] s1_data;
   logic [3:0]  s1_k;
   logic [3:0]  s1_de;

   // link counters
   logic [WCW-1:0] wc;
   logic [MFW-1:0] mf;
   logic [KCW-1:0] kcnt;
   logic [ECW-1:0] ecnt;

   // stage 2 / descrambler
   logic [31:0] s2_data;
   logic        s2_valid;
   logic [7:0]  prev3;
   logic [14:0] lfsr;

   // combinational helpers
   logic [7:0]     oct0;
   logic [7:0]     oct1;
   logic [7:0]     oct2;
   logic [7:0]     oct3;
   logic           all_k;
   logic           word_err;
   logic           is_r;
   logic           is_q;
   logic           is_a;
   logic           ilas_bad;
   logic           sync_d;
   logic [KCW-1:0] kcnt_inc;
   logic [ECW-1:0] ecnt_inc;
   logic [WCW-1:0] wc_wrap;
   logic           rep_mark;
   logic [7:0]     rest3;
   logic [14:0]    hist;
   logic [31:0]    plain;
   logic [31:0]    s3_word;

   // register the PHY word once before any decision is made on it
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         s1_data <= '0;
         s1_k    <= '0;
         s1_de   <= '0;
      end else begin
         s1_data <= rx_par_data;
         s1_k    <= rx_datak;
         s1_de   <= rx_disperr;
      end
   end

   // decode control characters and error conditions of the stage-1 word
   always_comb begin
      oct0     = s1_data[7:0];
      oct1     = s1_data[15:8];
      oct2     = s1_data[23:16];
      oct3     = s1_data[31:24];
      all_k    = (s1_data == 32'hBCBC_BCBC) && (s1_k == 4'hF);
      is_r     = (oct0 == 8'h1C) && s1_k[0];
      is_q     = (oct1 == 8'h9C) && s1_k[1];
      is_a     = (oct3 == 8'h7C) && s1_k[3];
      word_err = (|s1_de) || ((state == DATA) && (|s1_k[2:0]));
      kcnt_inc = kcnt + KCW'(1);
      ecnt_inc = ecnt + ECW'(1);
      wc_wrap  = (wc == WC_LAST) ? '0 : wc + WCW'(1);
   end

   // FSM state register; sync_b follows the state being entered
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state  <= SYNC_REQ;
         sync_b <= 1'b0;
      end else begin
         state  <= next;
         sync_b <= sync_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      next     = state;
      ilas_bad = 1'b0;
      unique case (state)
         SYNC_REQ: begin
            if (all_k) next = CGS;
         end
         CGS: begin
            if (!all_k)
               next = SYNC_REQ;
            else if (kcnt_inc == K_MIN)
               next = WAIT_ILAS;
         end
         WAIT_ILAS: begin
            if (is_r)
               next = ILAS;
            else if (!all_k)
               next = SYNC_REQ;
         end
         ILAS: begin
            if ((wc == '0) && !is_r)
               ilas_bad = 1'b1;
            if ((wc == WC_LAST) && !is_a)
               ilas_bad = 1'b1;
            if ((mf == MFW'(1)) && (wc == '0) && !is_q)
               ilas_bad = 1'b1;
            if (|s1_de)
               ilas_bad = 1'b1;
            if (ilas_bad)
               next = SYNC_REQ;
            else if ((wc == WC_LAST) && (mf == MF_LAST))
               next = DATA;
         end
         DATA: begin
            if (word_err && (ecnt_inc == E_LIM))
               next = SYNC_REQ;
            else if (all_k && (kcnt_inc == K_MIN))
               next = SYNC_REQ;
         end
         default: next = SYNC_REQ;
      endcase
   end

   // FSM outputs
   always_comb begin
      sync_d = 1'b1;
      unique case (next)
         SYNC_REQ, CGS: sync_d = 1'b0;
         default:       sync_d = 1'b1;
      endcase
      state_out = {5'd0, state};
   end

   // consecutive all-K counter, shared by CGS and in-DATA resync detection
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         kcnt <= '0;
      end else begin
         unique case (state)
            SYNC_REQ:  kcnt <= all_k ? KCW'(1) : '0;
            CGS, DATA: kcnt <= all_k ? kcnt_inc : '0;
            default:   kcnt <= '0;
         endcase
      end
   end

   // word and multiframe position; R in WAIT_ILAS marks word 0 of frame 0
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wc <= '0;
         mf <= '0;
      end else if ((state == WAIT_ILAS) && is_r) begin
         wc <= WCW'(1);
         mf <= '0;
      end else if (state == ILAS) begin
         wc <= wc_wrap;
         if (wc == WC_LAST) mf <= mf + MFW'(1);
      end else if (state == DATA) begin
         wc <= wc_wrap;
      end else begin
         wc <= '0;
         mf <= '0;
      end
   end

   // consecutive errored-word run length while in DATA
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)
         ecnt <= '0;
      else if (state == DATA)
         ecnt <= word_err ? ecnt_inc : '0;
      else
         ecnt <= '0;
   end

   // saturating total of errored words seen outside SYNC_REQ
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)
         err_cnt <= '0;
      else if ((state != SYNC_REQ) && word_err && (err_cnt != 16'hFFFF))
         err_cnt <= err_cnt + 16'd1;
   end

   // capture configuration octets from the second ILAS multiframe
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         ilas_cfg <= '0;
      end else if ((state == ILAS) && (mf == MFW'(1))) begin
         if (wc == WCW'(0)) ilas_cfg[15:0]   <= {oct3, oct2};
         if (wc == WCW'(1)) ilas_cfg[47:16]  <= s1_data;
         if (wc == WCW'(2)) ilas_cfg[79:48]  <= s1_data;
         if (wc == WCW'(3)) ilas_cfg[111:80] <= s1_data;
      end
   end

   // detect an F/A replacement marker in the last octet of the frame
   always_comb begin
      rep_mark = 1'b0;
      if ((state == DATA) && s1_k[3]) begin
         if (wc == WC_LAST)
            rep_mark = (oct3 == 8'h7C);
         else
            rep_mark = (oct3 == 8'hFC);
      end
      rest3 = rep_mark ? prev3 : oct3;
   end

   // stage 2: restored word; last restored octet3 seeds the next marker
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         s2_data  <= '0;
         s2_valid <= 1'b0;
         prev3    <= '0;
      end else begin
         s2_data  <= {rest3, s1_data[23:0]};
         s2_valid <= (state == DATA);
         prev3    <= (state == DATA) ? rest3 : 8'h00;
      end
   end

   // self-synchronous descrambler, octet0 MSB first; hist[0] is newest bit
   always_comb begin
      hist  = lfsr;
      plain = '0;
      for (int o = 0; o < 4; o++) begin
         for (int b = 7; b >= 0; b--) begin
            plain[8*o+b] = s2_data[8*o+b] ^ hist[13] ^ hist[14];
            hist = {hist[13:0], s2_data[8*o+b]};
         end
      end
      s3_word = descrambler_is_on ? plain : s2_data;
   end

   // stage 3: LFSR always tracks the received stream; I/Q output registers
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         lfsr      <= '0;
         rx_data_i <= '0;
         rx_data_q <= '0;
         rx_valid  <= 1'b0;
      end else begin
         lfsr      <= hist;
         rx_data_i <= {s3_word[7:0], s3_word[15:8]};
         rx_data_q <= {s3_word[23:16], s3_word[31:24]};
         rx_valid  <= s2_valid;
      end
   end

endmodule
